dot_engine_arbiter: RTL



---
 rtl/dot_engine_arbiter.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/dot_engine_arbiter.sv
// Round-robin arbiter sharing one AXI4-Stream dot-product engine between two requesters.
// Define ARB_PERF_EN to add per-requester transaction counters and a wait-cycle counter.
//
// state | meaning
// IDLE  | no owner; pick a requester, no stream passes
// SEND  | owner's input frame streams to the engine, results routed back to owner
// DRAIN | input frame done; remaining result beats routed back to owner
module dot_engine_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int MAX_IDLE_GRANT = 0
) (
  input  logic                  aclk,
  input  logic                  aresetn,

  input  logic [DATA_WIDTH-1:0] S0_AXIS_TDATA,
  input  logic                  S0_AXIS_TLAST,
  input  logic                  S0_AXIS_TVALID,
  output logic                  S0_AXIS_TREADY,

  input  logic [DATA_WIDTH-1:0] S1_AXIS_TDATA,
  input  logic                  S1_AXIS_TLAST,
  input  logic                  S1_AXIS_TVALID,
  output logic                  S1_AXIS_TREADY,

  output logic [DATA_WIDTH-1:0] ENG_IN_AXIS_TDATA,
  output logic                  ENG_IN_AXIS_TLAST,
  output logic                  ENG_IN_AXIS_TVALID,
  input  logic                  ENG_IN_AXIS_TREADY,

  input  logic [DATA_WIDTH-1:0] ENG_OUT_AXIS_TDATA,
  input  logic                  ENG_OUT_AXIS_TLAST,
  input  logic                  ENG_OUT_AXIS_TVALID,
  output logic                  ENG_OUT_AXIS_TREADY,

  output logic [DATA_WIDTH-1:0] M0_AXIS_TDATA,
  output logic                  M0_AXIS_TLAST,
  output logic                  M0_AXIS_TVALID,
  input  logic                  M0_AXIS_TREADY,

  output logic [DATA_WIDTH-1:0] M1_AXIS_TDATA,
  output logic                  M1_AXIS_TLAST,
  output logic                  M1_AXIS_TVALID,
  input  logic                  M1_AXIS_TREADY,

`ifdef ARB_PERF_EN
  output logic [31:0]           XACT0_COUNT,
  output logic [31:0]           XACT1_COUNT,
  output logic [31:0]           WAIT_CYCLES,
`endif

  output logic                  BUSY,
  output logic                  GRANT
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state;
  logic   grant_q;
  logic   prio_q;
  logic   in_done_q;
  logic   busy_q;
  logic   in_last_beat;
  logic   out_last_beat;
  logic   xact_done;

  if (MAX_IDLE_GRANT != 0) begin : g_cfg_check
    $error("dot_engine_arbiter: MAX_IDLE_GRANT is reserved and must be 0");
  end

  always_comb begin
    ENG_IN_AXIS_TDATA  = '0;
    ENG_IN_AXIS_TLAST  = 1'b0;
    ENG_IN_AXIS_TVALID = 1'b0;
    S0_AXIS_TREADY     = 1'b0;
    S1_AXIS_TREADY     = 1'b0;
    if (state == SEND) begin
      if (grant_q) begin
        ENG_IN_AXIS_TDATA  = S1_AXIS_TDATA;
        ENG_IN_AXIS_TLAST  = S1_AXIS_TLAST;
        ENG_IN_AXIS_TVALID = S1_AXIS_TVALID;
        S1_AXIS_TREADY     = ENG_IN_AXIS_TREADY;
      end else begin
        ENG_IN_AXIS_TDATA  = S0_AXIS_TDATA;
        ENG_IN_AXIS_TLAST  = S0_AXIS_TLAST;
        ENG_IN_AXIS_TVALID = S0_AXIS_TVALID;
        S0_AXIS_TREADY     = ENG_IN_AXIS_TREADY;
      end
    end
  end

  // Results may start coming back while the input frame is still streaming.
  always_comb begin
    M0_AXIS_TDATA       = '0;
    M0_AXIS_TLAST       = 1'b0;
    M0_AXIS_TVALID      = 1'b0;
    M1_AXIS_TDATA       = '0;
    M1_AXIS_TLAST       = 1'b0;
    M1_AXIS_TVALID      = 1'b0;
    ENG_OUT_AXIS_TREADY = 1'b0;
    if (state != IDLE) begin
      if (grant_q) begin
        M1_AXIS_TDATA       = ENG_OUT_AXIS_TDATA;
        M1_AXIS_TLAST       = ENG_OUT_AXIS_TLAST;
        M1_AXIS_TVALID      = ENG_OUT_AXIS_TVALID;
        ENG_OUT_AXIS_TREADY = M1_AXIS_TREADY;
      end else begin
        M0_AXIS_TDATA       = ENG_OUT_AXIS_TDATA;
        M0_AXIS_TLAST       = ENG_OUT_AXIS_TLAST;
        M0_AXIS_TVALID      = ENG_OUT_AXIS_TVALID;
        ENG_OUT_AXIS_TREADY = M0_AXIS_TREADY;
      end
    end
  end

  assign in_last_beat  = ENG_IN_AXIS_TVALID & ENG_IN_AXIS_TREADY & ENG_IN_AXIS_TLAST;
  assign out_last_beat = ENG_OUT_AXIS_TVALID & ENG_OUT_AXIS_TREADY & ENG_OUT_AXIS_TLAST;
  assign xact_done     = (state == DRAIN) & (out_last_beat | in_done_q);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state     <= IDLE;
      grant_q   <= 1'b0;
      prio_q    <= 1'b0;
      in_done_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (S0_AXIS_TVALID | S1_AXIS_TVALID) begin
            grant_q <= (S0_AXIS_TVALID & S1_AXIS_TVALID) ? prio_q : S1_AXIS_TVALID;
            state   <= SEND;
            busy_q  <= 1'b1;
          end
        end
        SEND: begin
          if (out_last_beat) in_done_q <= 1'b1;
          if (in_last_beat)  state     <= DRAIN;
        end
        DRAIN: begin
          if (xact_done) begin
            state     <= IDLE;
            busy_q    <= 1'b0;
            prio_q    <= ~grant_q;
            in_done_q <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign BUSY  = busy_q;
  assign GRANT = grant_q;

`ifdef ARB_PERF_EN
  logic [31:0] xact0_q;
  logic [31:0] xact1_q;
  logic [31:0] wait_q;
  logic        wait0;
  logic        wait1;

  // A requester is waiting whenever it has TVALID up and is not the active owner.
  assign wait0 = S0_AXIS_TVALID & ~((state != IDLE) & ~grant_q);
  assign wait1 = S1_AXIS_TVALID & ~((state != IDLE) &  grant_q);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      xact0_q <= '0;
      xact1_q <= '0;
      wait_q  <= '0;
    end else begin
      if (xact_done & ~grant_q) xact0_q <= xact0_q + 32'd1;
      if (xact_done &  grant_q) xact1_q <= xact1_q + 32'd1;
      if (wait0 | wait1)        wait_q  <= wait_q + 32'd1;
    end
  end

  assign XACT0_COUNT = xact0_q;
  assign XACT1_COUNT = xact1_q;
  assign WAIT_CYCLES = wait_q;
`endif

endmodule
